// File: rtl/bcd_pkg.sv
// Shared FSM state type and digit-adjust constants for the sequential
// binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decade.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj
);

  assign adj = (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ_ADD : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one shift-and-adjust step per clock.
// Define BIN2BCD_OVF_EN to add the sticky `ovf` output for truncated results.
//
// state | meaning
// IDLE  | in_ready high, waiting for in_valid to load a new value
// SHIFT | busy, one adjust+shift per cycle for WIDTH cycles
// DONE  | out_valid high, bcd held until out_ready
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
`ifdef BIN2BCD_OVF_EN
  ,
  output logic                          ovf
`endif
);

  localparam int              BW        = BCD_DIGIT_W * DIGITS;
  localparam int              CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);

  bcd_state_t     state;
  logic [WIDTH-1:0] bin_sr;
  logic [CW-1:0]  step_cnt;
  logic [BW-1:0]  bcd_adj;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (bcd[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adj   (bcd_adj[k*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == SHIFT);
  assign out_valid = (state == DONE);

`ifndef BIN2BCD_OVF_EN
  // The carry out of the top digit is simply dropped in this build.
  logic drop_unused;
  assign drop_unused = bcd_adj[BW-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bin_sr   <= '0;
      bcd      <= '0;
      step_cnt <= '0;
`ifdef BIN2BCD_OVF_EN
      ovf      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_sr   <= in_data;
            bcd      <= '0;
            step_cnt <= '0;
`ifdef BIN2BCD_OVF_EN
            ovf      <= 1'b0;
`endif
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd      <= {bcd_adj[BW-2:0], bin_sr[WIDTH-1]};
          bin_sr   <= bin_sr << 1;
          step_cnt <= step_cnt + CW'(1);
`ifdef BIN2BCD_OVF_EN
          ovf      <= ovf | bcd_adj[BW-1];
`endif
          if (step_cnt == LAST_STEP) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: three instances (8/3, 8/2, 1/1)
// checked against a decimal-digit reference computed with plain arithmetic.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance a: WIDTH=8, DIGITS=3
  logic [7:0]  a_in_data;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [11:0] a_bcd;
  // Instance b: WIDTH=8, DIGITS=2
  logic [7:0]  b_in_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [7:0]  b_bcd;
  // Instance c: WIDTH=1, DIGITS=1
  logic [0:0]  c_in_data;
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
  logic [3:0]  c_bcd;
`ifdef BIN2BCD_OVF_EN
  logic a_ovf, b_ovf, c_ovf;
`endif

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .bcd(a_bcd), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .busy(a_busy)
`ifdef BIN2BCD_OVF_EN
    , .ovf(a_ovf)
`endif
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .bcd(b_bcd), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .busy(b_busy)
`ifdef BIN2BCD_OVF_EN
    , .ovf(b_ovf)
`endif
  );

  bin2bcd_seq #(.WIDTH(1), .DIGITS(1)) dut_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .bcd(c_bcd), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .busy(c_busy)
`ifdef BIN2BCD_OVF_EN
    , .ovf(c_ovf)
`endif
  );

  // Reference: decimal digits of v, keeping only the lowest `digits` decades.
  function automatic logic [11:0] ref_bcd(int v, int digits);
    logic [11:0] res;
    int r;
    res = '0;
    r = v;
    for (int i = 0; i < digits; i++) begin
      res[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return res;
  endfunction

  function automatic logic sel_out_valid(int sel);
    case (sel)
      0:       return a_out_valid;
      1:       return b_out_valid;
      default: return c_out_valid;
    endcase
  endfunction

  function automatic logic [11:0] sel_bcd(int sel);
    case (sel)
      0:       return a_bcd;
      1:       return {4'h0, b_bcd};
      default: return {8'h00, c_bcd};
    endcase
  endfunction

  // Called at a negedge with the target instance idle. Returns at the negedge
  // where out_valid is first seen, with the number of edges since the accept.
  task automatic run_conv(input int sel, input int v, output logic [11:0] got,
                          output int lat);
    int n;
    case (sel)
      0:       begin a_in_data = 8'(v); a_in_valid = 1'b1; end
      1:       begin b_in_data = 8'(v); b_in_valid = 1'b1; end
      default: begin c_in_data = 1'(v); c_in_valid = 1'b1; end
    endcase
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    c_in_valid = 1'b0;
    n = 0;
    while (!sel_out_valid(sel) && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL timeout sel=%0d value=%0d no out_valid within 40 cycles", sel, v);
    end
    got = sel_bcd(sel);
    lat = n;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", a_out_valid); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", a_busy); end
    checks++; if (a_bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd got %h exp 000", a_bcd); end
    checks++; if (b_bcd !== 8'h00) begin errors++; $display("FAIL reset_bcd_b got %h exp 00", b_bcd); end
`ifdef BIN2BCD_OVF_EN
    checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", b_ovf); end
`endif
  endtask

  task automatic test_latency_255();
    logic [11:0] got;
    int lat;
    a_out_ready = 1'b1;
    run_conv(0, 255, got, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL lat_255 got %0d exp 8", lat); end
    checks++; if (got !== 12'h255) begin errors++; $display("FAIL bcd_255 got %h exp 255", got); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_done got %b exp 0", a_in_ready); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL busy_done got %b exp 0", a_busy); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_after got %b exp 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL out_valid_after got %b exp 0", a_out_valid); end
  endtask

  task automatic test_back_to_back_sweep();
    logic [11:0] got;
    int lat;
    a_out_ready = 1'b1;
    for (int v = 0; v < 256; v++) begin
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready value=%0d got %b exp 1", v, a_in_ready); end
      run_conv(0, v, got, lat);
      checks++; if (got !== ref_bcd(v, 3)) begin errors++; $display("FAIL sweep_bcd value=%0d got %h exp %h", v, got, ref_bcd(v, 3)); end
      checks++; if (lat !== 8) begin errors++; $display("FAIL sweep_lat value=%0d got %0d exp 8", v, lat); end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [11:0] got;
    int lat;
    a_out_ready = 1'b0;
    run_conv(0, 42, got, lat);
    checks++; if (got !== 12'h042) begin errors++; $display("FAIL stall_bcd got %h exp 042", got); end
    a_in_data  = 8'd7;
    a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc=%0d got %b exp 1", i, a_out_valid); end
      checks++; if (a_bcd !== 12'h042) begin errors++; $display("FAIL stall_hold cyc=%0d got %h exp 042", i, a_bcd); end
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got %b exp 0", i, a_in_ready); end
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", a_in_ready); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL stall_ignored busy got %b exp 0", a_busy); end
    checks++; if (a_bcd !== 12'h042) begin errors++; $display("FAIL stall_bcd_idle got %h exp 042", a_bcd); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] got;
    int lat;
    a_out_ready = 1'b1;
    a_in_data   = 8'd123;
    a_in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", a_busy); end
    rst = 1'b1;
    #1;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", a_busy); end
    checks++; if (a_bcd !== 12'h000) begin errors++; $display("FAIL rst_bcd got %h exp 000", a_bcd); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", a_out_valid); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_conv(0, 7, got, lat);
    checks++; if (got !== 12'h007) begin errors++; $display("FAIL post_rst_bcd got %h exp 007", got); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL post_rst_lat got %0d exp 8", lat); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [11:0] got;
    int lat, v, stall;
    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(0, 255));
      stall = int'($urandom_range(0, 3));
      a_out_ready = 1'b0;
      run_conv(0, v, got, lat);
      checks++; if (got !== ref_bcd(v, 3)) begin errors++; $display("FAIL rand_bcd value=%0d got %h exp %h", v, got, ref_bcd(v, 3)); end
      repeat (stall) begin @(posedge clk); @(negedge clk); end
      checks++; if (a_bcd !== ref_bcd(v, 3)) begin errors++; $display("FAIL rand_hold value=%0d got %h exp %h", v, a_bcd, ref_bcd(v, 3)); end
      a_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_two_digits();
    logic [11:0] got;
    int lat, v;
    int fixed_vals[5] = '{199, 200, 57, 99, 100};
    b_out_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      v = (i < 5) ? fixed_vals[i] : int'($urandom_range(0, 255));
      run_conv(1, v, got, lat);
      checks++; if (got !== ref_bcd(v, 2)) begin errors++; $display("FAIL d2_bcd value=%0d got %h exp %h", v, got, ref_bcd(v, 2)); end
`ifdef BIN2BCD_OVF_EN
      checks++; if (b_ovf !== (v > 99)) begin errors++; $display("FAIL d2_ovf value=%0d got %b exp %b", v, b_ovf, (v > 99)); end
`endif
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_width1();
    logic [11:0] got;
    int lat;
    int vals[3] = '{1, 0, 1};
    c_out_ready = 1'b1;
    foreach (vals[i]) begin
      run_conv(2, vals[i], got, lat);
      checks++; if (got !== 12'(vals[i])) begin errors++; $display("FAIL w1_bcd value=%0d got %h exp %0d", vals[i], got, vals[i]); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL w1_lat value=%0d got %0d exp 1", vals[i], lat); end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    c_in_data = '0; c_in_valid = 1'b0; c_out_ready = 1'b0;
    test_reset();
    test_latency_255();
    test_back_to_back_sweep();
    test_stall();
    test_reset_mid();
    test_random();
    test_two_digits();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
